pwm_ch_update_seq: RTL and testbench

- Command-driven sequencer that reprograms one PWM channel's full setting in the PWM register block with one handshake: compare start, compare end, dead-time and config.
- Sits between the host/command source and the register block's write/read bus, and is the sole master of that bus.
- Validates the command against the owning core's auto-reload value before any write, then issues the four register writes back-to-back.

---
 rtl/pwm_ch_update_seq_pkg.sv | 40 ++++
 rtl/pwm_ch_update_seq_cmd_check.sv | 25 ++
 rtl/pwm_ch_update_seq.sv | 189 ++++++++++++++++++
 tb/tb_pwm_ch_update_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ch_update_seq_pkg.sv
// Shared constants, state encoding and address helpers for the PWM channel update sequencer.
// The PWM_SEQ_CEN_GATE_EN states are declared unconditionally and are only reached when that macro is defined.
package pwm_pkg;

    localparam int unsigned ADDR_CEN      = 0;
    localparam int unsigned ADDR_ARR_BASE = 2;
    localparam int unsigned ADDR_CH_BASE  = 10;
    localparam int unsigned CH_STRIDE     = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_ARR,
        ST_ERR,
        ST_RD_CEN,
        ST_WR_CEN_OFF,
        ST_WR_START,
        ST_WR_END,
        ST_WR_DTG,
        ST_WR_CFG,
        ST_WR_CEN_RESTORE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ORDER = 2'd1,
        ERR_ARR   = 2'd2,
        ERR_DTG   = 2'd3
    } err_code_e;

    // Each core owns two channels; its ARR registers sit on even addresses from ADDR_ARR_BASE.
    function automatic logic [7:0] arr_addr(input logic [2:0] ch);
        return 8'(ADDR_ARR_BASE) + {6'd0, ch[2:1]} * 8'd2;
    endfunction

    function automatic logic [7:0] ch_reg_addr(input logic [2:0] ch, input logic [1:0] off);
        return 8'(ADDR_CH_BASE) + {5'd0, ch} * 8'(CH_STRIDE) + {6'd0, off};
    endfunction

endpackage

// File: rtl/pwm_ch_update_seq_cmd_check.sv
// Combinational command validator returning the highest-priority error code.
module pwm_cmd_check
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] start_i,
    input  logic [WIDTH-1:0] end_i,
    input  logic [7:0]       dtg_i,
    input  logic [WIDTH-1:0] arr_i,
    output logic [1:0]       code_o
);

    always_comb begin
        code_o = ERR_NONE;
        if (start_i > end_i) begin
            code_o = ERR_ORDER;
        end else if (end_i > arr_i) begin
            code_o = ERR_ARR;
        end else if (dtg_i == 8'd0) begin
            code_o = ERR_DTG;
        end
    end

endmodule

// File: rtl/pwm_ch_update_seq.sv
// Validates a channel update against its core's ARR, then writes start/end/dtg/cfg back-to-back.
// Optional macro PWM_SEQ_CEN_GATE_EN stops the owning counter (CEN bit) for the duration of the writes.
module pwm_ch_update_seq
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_ch_i,
    input  logic [WIDTH-1:0] cmd_start_i,
    input  logic [WIDTH-1:0] cmd_end_i,
    input  logic [7:0]       cmd_dtg_i,
    input  logic [WIDTH-1:0] cmd_cfg_i,
    output logic             reg_wr_en_o,
    output logic             reg_rd_en_o,
    output logic [7:0]       reg_addr_o,
    output logic [WIDTH-1:0] reg_wr_data_o,
    input  logic [WIDTH-1:0] reg_rd_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    state_e           state_q;
    logic [2:0]       ch_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] end_q;
    logic [7:0]       dtg_q;
    logic [WIDTH-1:0] cfg_q;
`ifdef PWM_SEQ_CEN_GATE_EN
    logic [WIDTH-1:0] cen_q;
`endif
    logic             ready_q;
    logic             wr_en_q;
    logic             rd_en_q;
    logic [7:0]       addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [1:0]       chk_code;

    pwm_cmd_check #(.WIDTH(WIDTH)) u_cmd_check (
        .start_i (start_q),
        .end_i   (end_q),
        .dtg_i   (dtg_q),
        .arr_i   (reg_rd_data_i),
        .code_o  (chk_code)
    );

    // Bus outputs are registered alongside the state, so each transition loads the strobes of the state it enters.
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            start_q    <= '0;
            end_q      <= '0;
            dtg_q      <= '0;
            cfg_q      <= '0;
`ifdef PWM_SEQ_CEN_GATE_EN
            cen_q      <= '0;
`endif
            ready_q    <= 1'b1;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && ready_q) begin
                        ch_q       <= cmd_ch_i;
                        start_q    <= cmd_start_i;
                        end_q      <= cmd_end_i;
                        dtg_q      <= cmd_dtg_i;
                        cfg_q      <= cmd_cfg_i;
                        err_code_q <= ERR_NONE;
                        ready_q    <= 1'b0;
                        state_q    <= ST_RD_ARR;
                        rd_en_q    <= 1'b1;
                        addr_q     <= arr_addr(cmd_ch_i);
                    end
                end
                ST_RD_ARR: begin
                    if (chk_code != ERR_NONE) begin
                        state_q    <= ST_ERR;
                        err_q      <= 1'b1;
                        err_code_q <= chk_code;
                    end else begin
`ifdef PWM_SEQ_CEN_GATE_EN
                        state_q <= ST_RD_CEN;
                        rd_en_q <= 1'b1;
                        addr_q  <= 8'(ADDR_CEN);
`else
                        state_q <= ST_WR_START;
                        wr_en_q <= 1'b1;
                        addr_q  <= ch_reg_addr(ch_q, 2'd0);
                        wdata_q <= start_q;
`endif
                    end
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
`ifdef PWM_SEQ_CEN_GATE_EN
                ST_RD_CEN: begin
                    cen_q   <= reg_rd_data_i;
                    state_q <= ST_WR_CEN_OFF;
                    wr_en_q <= 1'b1;
                    addr_q  <= 8'(ADDR_CEN);
                    wdata_q <= reg_rd_data_i & ~(WIDTH'(1) << ch_q[2:1]);
                end
                ST_WR_CEN_OFF: begin
                    state_q <= ST_WR_START;
                    wr_en_q <= 1'b1;
                    addr_q  <= ch_reg_addr(ch_q, 2'd0);
                    wdata_q <= start_q;
                end
                ST_WR_CEN_RESTORE: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
`endif
                ST_WR_START: begin
                    state_q <= ST_WR_END;
                    wr_en_q <= 1'b1;
                    addr_q  <= ch_reg_addr(ch_q, 2'd1);
                    wdata_q <= end_q;
                end
                ST_WR_END: begin
                    state_q <= ST_WR_DTG;
                    wr_en_q <= 1'b1;
                    addr_q  <= ch_reg_addr(ch_q, 2'd2);
                    wdata_q <= WIDTH'(dtg_q);
                end
                ST_WR_DTG: begin
                    state_q <= ST_WR_CFG;
                    wr_en_q <= 1'b1;
                    addr_q  <= ch_reg_addr(ch_q, 2'd3);
                    wdata_q <= cfg_q;
                end
                ST_WR_CFG: begin
`ifdef PWM_SEQ_CEN_GATE_EN
                    state_q <= ST_WR_CEN_RESTORE;
                    wr_en_q <= 1'b1;
                    addr_q  <= 8'(ADDR_CEN);
                    wdata_q <= cen_q;
`else
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
`endif
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o   = ready_q;
    assign reg_wr_en_o   = wr_en_q;
    assign reg_rd_en_o   = rd_en_q;
    assign reg_addr_o    = addr_q;
    assign reg_wr_data_o = wdata_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_pwm_ch_update_seq.sv
// Directed plus randomized bench for pwm_ch_update_seq against a register-block model and an op-list reference.
module tb_pwm_ch_update_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ch = '0;
    logic [15:0] cmd_start = '0;
    logic [15:0] cmd_end = '0;
    logic [7:0]  cmd_dtg = '0;
    logic [15:0] cmd_cfg = '0;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic [15:0] reg_rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [15:0] mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [15:0] poke_data = '0;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [7:0]  addr;
        logic [15:0] data;
    } op_t;

    pwm_ch_update_seq #(.WIDTH(16)) dut (
        .clk_psc_i     (clk),
        .rst_n_i       (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_ch_i      (cmd_ch),
        .cmd_start_i   (cmd_start),
        .cmd_end_i     (cmd_end),
        .cmd_dtg_i     (cmd_dtg),
        .cmd_cfg_i     (cmd_cfg),
        .reg_wr_en_o   (reg_wr_en),
        .reg_rd_en_o   (reg_rd_en),
        .reg_addr_o    (reg_addr),
        .reg_wr_data_o (reg_wr_data),
        .reg_rd_data_i (reg_rd_data),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .err_code_o    (err_code)
    );

    always #5 clk = ~clk;

    // Register block model: combinational read, write at the rising edge.
    assign reg_rd_data = reg_rd_en ? mem[reg_addr] : 16'h0000;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    function automatic logic [1:0] ref_code(input logic [15:0] s, input logic [15:0] e,
                                            input logic [7:0] d, input logic [15:0] arr);
        if (s > e) return 2'd1;
        if (e > arr) return 2'd2;
        if (d == 8'd0) return 2'd3;
        return 2'd0;
    endfunction

    // Issue one command and check every cycle of the resulting bus trace.
    task automatic run_cmd(input logic [2:0] ch, input logic [15:0] s, input logic [15:0] e,
                           input logic [7:0] d, input logic [15:0] cfg, input bit hold);
        op_t         ops[$];
        int unsigned core, base, arr_a;
        logic [15:0] arr, cen;
        logic [1:0]  code;
        core  = int'(ch) / 2;
        base  = 10 + 4 * int'(ch);
        arr_a = 2 + 2 * core;
        arr   = mem[arr_a];
        cen   = mem[0];
        code  = ref_code(s, e, d, arr);
        ops.push_back('{wr: 0, rd: 1, addr: 8'(arr_a), data: 16'h0});
        if (code == 2'd0) begin
`ifdef PWM_SEQ_CEN_GATE_EN
            ops.push_back('{wr: 0, rd: 1, addr: 8'd0, data: 16'h0});
            ops.push_back('{wr: 1, rd: 0, addr: 8'd0, data: cen & ~(16'd1 << core)});
`endif
            ops.push_back('{wr: 1, rd: 0, addr: 8'(base),     data: s});
            ops.push_back('{wr: 1, rd: 0, addr: 8'(base + 1), data: e});
            ops.push_back('{wr: 1, rd: 0, addr: 8'(base + 2), data: {8'h00, d}});
            ops.push_back('{wr: 1, rd: 0, addr: 8'(base + 3), data: cfg});
`ifdef PWM_SEQ_CEN_GATE_EN
            ops.push_back('{wr: 1, rd: 0, addr: 8'd0, data: cen});
`endif
        end

        @(negedge clk);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_ch = ch; cmd_start = s; cmd_end = e; cmd_dtg = d; cmd_cfg = cfg;
        cmd_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        foreach (ops[i]) begin
            chk("op_wr_en",   32'(reg_wr_en), 32'(ops[i].wr));
            chk("op_rd_en",   32'(reg_rd_en), 32'(ops[i].rd));
            chk("op_addr",    32'(reg_addr), 32'(ops[i].addr));
            chk("op_wdata",   32'(reg_wr_data), 32'(ops[i].wr ? ops[i].data : 16'h0));
            chk("op_busy",    32'(busy), 32'd1);
            chk("op_ready",   32'(cmd_ready), 32'd0);
            chk("op_done",    32'(done), 32'd0);
            chk("op_err",     32'(err), 32'd0);
            chk("op_errcode", 32'(err_code), 32'd0);
            @(negedge clk);
        end
        chk("term_done",    32'(done), 32'(code == 2'd0));
        chk("term_err",     32'(err), 32'(code != 2'd0));
        chk("term_errcode", 32'(err_code), 32'(code));
        chk("term_wr_en",   32'(reg_wr_en), 32'd0);
        chk("term_rd_en",   32'(reg_rd_en), 32'd0);
        chk("term_busy",    32'(busy), 32'd1);
        @(negedge clk);
        chk("idle_ready",   32'(cmd_ready), 32'd1);
        chk("idle_busy",    32'(busy), 32'd0);
        chk("idle_done",    32'(done), 32'd0);
        chk("idle_err",     32'(err), 32'd0);
        chk("idle_errcode", 32'(err_code), 32'(code));
        if (code == 2'd0) begin
            chk("mem_start", 32'(mem[base]), 32'(s));
            chk("mem_end",   32'(mem[base + 1]), 32'(e));
            chk("mem_dtg",   32'(mem[base + 2]), 32'(d));
            chk("mem_cfg",   32'(mem[base + 3]), 32'(cfg));
            chk("mem_cen",   32'(mem[0]), 32'(cen));
        end
    endtask

    initial begin
        logic [2:0]  rch;
        logic [15:0] rarr, rs, re;
        logic [7:0]  rd;
        int unsigned wr_end_k, guard;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(cmd_ready), 32'd1);
        chk("rst_wr_en",   32'(reg_wr_en), 32'd0);
        chk("rst_rd_en",   32'(reg_rd_en), 32'd0);
        chk("rst_addr",    32'(reg_addr), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_errcode", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Valid update on ch 2 (core 1, ARR at 4)
        poke(8'd4, 16'd1000);
        run_cmd(3'd2, 16'd100, 16'd200, 8'd5, 16'h0003, 1'b0);

        // ARR violation on ch 7 (ARR at 8)
        poke(8'd8, 16'd1000);
        run_cmd(3'd7, 16'd100, 16'd1200, 8'd5, 16'h0001, 1'b0);

        // Priority: order error masks dtg==0
        poke(8'd2, 16'd1000);
        run_cmd(3'd0, 16'd300, 16'd200, 8'd0, 16'h0000, 1'b0);

        // Boundaries: start==end==ARR passes; dtg==0 alone rejected
        poke(8'd6, 16'd500);
        run_cmd(3'd5, 16'd500, 16'd500, 8'd1, 16'h00A5, 1'b0);
        run_cmd(3'd4, 16'd10, 16'd20, 8'd0, 16'h0000, 1'b0);
        run_cmd(3'd3, 16'd0, 16'hFFFF, 8'd9, 16'h0000, 1'b0);

        // Counter-enable gating scenario; CEN register = 0xF
        poke(8'd0, 16'h000F);
        run_cmd(3'd7, 16'd10, 16'd20, 8'd3, 16'h0005, 1'b0);

        // Command held valid through completion is accepted in the following idle cycle
        run_cmd(3'd1, 16'd50, 16'd60, 8'd7, 16'h0011, 1'b1);
        @(negedge clk);
        chk("hold_reaccept_rd", 32'(reg_rd_en), 32'd1);
        chk("hold_reaccept_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("hold_finish_in_time", 32'(busy), 32'd0);
        chk("hold_mem_end", 32'(mem[15]), 32'd60);

        // Asynchronous reset while WR_END is on the bus
        poke(8'd4, 16'd2000);
        poke(8'd23, 16'h1234);
`ifdef PWM_SEQ_CEN_GATE_EN
        wr_end_k = 5;
`else
        wr_end_k = 3;
`endif
        @(negedge clk);
        cmd_ch = 3'd3; cmd_start = 16'd111; cmd_end = 16'd222; cmd_dtg = 8'd4; cmd_cfg = 16'h0002;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k < int'(wr_end_k); k++) @(negedge clk);
        chk("mid_wr_end_strobe", 32'(reg_wr_en), 32'd1);
        chk("mid_wr_end_addr", 32'(reg_addr), 32'd23);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_mid_addr", 32'(reg_addr), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rel_busy", 32'(busy), 32'd0);
        chk("rst_kept_start", 32'(mem[22]), 32'd111);
        chk("rst_no_end", 32'(mem[23]), 32'h1234);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            rch  = 3'($urandom_range(0, 7));
            rarr = 16'($urandom_range(100, 60000));
            poke(8'(2 + 2 * (int'(rch) / 2)), rarr);
            re = 16'($urandom_range(0, int'(rarr) + 200));
            rs = 16'($urandom_range(0, int'(re) + 50));
            if ($urandom_range(0, 9) == 0) re = rarr;
            rd = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_cmd(rch, rs, re, rd, 16'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
